// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind a UART receiver, with a sticky overflow flag and an accepted-byte counter
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int TOTAL_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  input  logic [7:0]               IN_DATA,
  input  logic                     OUT_READY,
  input  logic                     CLR_OVF,
  output logic                     OUT_VALID,
  output logic [7:0]               OUT_DATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVERFLOW,
  output logic [TOTAL_W-1:0]       RX_TOTAL
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push, drop;
  // status flags come only from the registered count; a pop frees room for a same-cycle push
  always_comb begin
    OUT_VALID = COUNT != '0;
    EMPTY     = COUNT == '0;
    FULL      = COUNT == (AW+1)'(DEPTH);
    OUT_DATA  = mem[rd_ptr];
    pop       = OUT_VALID && OUT_READY;
    push      = IN_VALID && (!FULL || pop);
    drop      = IN_VALID && FULL && !pop;
  end
  // pointers, occupancy, overflow flag and accepted-byte total; a new drop beats a clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
      RX_TOTAL <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      COUNT    <= push && !pop ? COUNT + (AW+1)'(1) : pop && !push ? COUNT - (AW+1)'(1) : COUNT;
      OVERFLOW <= drop || (OVERFLOW && !CLR_OVF);
      if (push) RX_TOTAL <= RX_TOTAL + TOTAL_W'(1);
    end
  end
  // storage needs no reset since the pointers define what is valid
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= IN_DATA;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with directed byte streams
module tb_uart_rx_fifo;
  logic        CLK = 1'b0;
  logic        RST_N, IN_VALID, OUT_READY, CLR_OVF;
  logic [7:0]  IN_DATA;
  logic        OUT_VALID, FULL, EMPTY, OVERFLOW;
  logic [7:0]  OUT_DATA;
  logic [4:0]  COUNT;
  logic [15:0] RX_TOTAL;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_total = '0;
  bit          mpop, mpush, mdrop;

  uart_rx_fifo #(.DEPTH(16), .TOTAL_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .OUT_READY(OUT_READY), .CLR_OVF(CLR_OVF), .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
    .OVERFLOW(OVERFLOW), .RX_TOTAL(RX_TOTAL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c);
    @(posedge CLK);
    #1;
    IN_VALID = v;
    IN_DATA = d;
    OUT_READY = r;
    CLR_OVF = c;
  endtask

  task automatic rst_pulse();
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_empty", EMPTY, 1);
    chk("async_rst_count", COUNT, 0);
    chk("async_rst_total", RX_TOTAL, 0);
    chk("async_rst_valid", OUT_VALID, 0);
    chk("async_rst_ovf", OVERFLOW, 0);
    q.delete();
    m_ovf = 1'b0;
    m_total = '0;
    RST_N = 1'b1;
  endtask

  // monitor: reference queue model checked every cycle, popped when the DUT presents and the consumer takes a byte
  always @(negedge CLK) begin
    if (!RST_N) begin
      q.delete();
      m_ovf = 1'b0;
      m_total = '0;
    end else begin
      mpop = q.size() > 0 && OUT_READY;
      mpush = IN_VALID && (q.size() < 16 || mpop);
      mdrop = IN_VALID && !mpush;
      chk("count", COUNT, q.size());
      chk("out_valid", OUT_VALID, q.size() > 0);
      chk("full", FULL, q.size() == 16);
      chk("overflow", OVERFLOW, m_ovf);
      chk("rx_total", RX_TOTAL, m_total);
      if (mpop) begin
        chk("out_data", OUT_DATA, q[0]);
        void'(q.pop_front());
      end
      if (mpush) begin
        q.push_back(IN_DATA);
        m_total++;
      end
      m_ovf = mdrop || (m_ovf && !CLR_OVF);
    end
  end

  initial begin
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA = '0;
    OUT_READY = 1'b0;
    CLR_OVF = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_count", COUNT, 0);
    RST_N = 1'b1;
    step(1, 8'h41, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("single_valid", OUT_VALID, 1);
    chk("single_data", OUT_DATA, 8'h41);
    chk("single_count", COUNT, 1);
    chk("single_total", RX_TOTAL, 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("single_drained", EMPTY, 1);
    rst_pulse();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'h55, 0, 0);
    chk("fill_full", FULL, 1);
    chk("fill_count", COUNT, 16);
    step(0, 8'h00, 0, 0);
    chk("drop_ovf", OVERFLOW, 1);
    chk("drop_total", RX_TOTAL, 16);
    chk("drop_count", COUNT, 16);
    step(0, 8'h00, 1, 1);
    for (int i = 1; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("drain_empty", EMPTY, 1);
    chk("drain_ovf_clr", OVERFLOW, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
    step(1, 8'hAA, 1, 0);
    chk("full_pp_before", COUNT, 16);
    step(0, 8'h00, 0, 0);
    chk("full_pp_count", COUNT, 16);
    chk("full_pp_ovf", OVERFLOW, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    chk("full_pp_last", OUT_DATA, 8'hAA);
    chk("full_pp_last_cnt", COUNT, 1);
    step(0, 8'h00, 0, 0);
    chk("full_pp_empty", EMPTY, 1);
    for (int i = 0; i < 40; i++) step(1, 8'(i * 37 + 5), i % 3 != 0, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("wrap_empty", EMPTY, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0);
    step(1, 8'hEE, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("clr_vs_drop", OVERFLOW, 1);
    step(0, 8'h00, 0, 0);
    chk("clr_alone", OVERFLOW, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("clr_drain_empty", EMPTY, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
    step(0, 8'h00, 0, 0);
    chk("pre_rst_count", COUNT, 5);
    rst_pulse();
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("post_rst_empty", EMPTY, 1);
    chk("post_rst_total", RX_TOTAL, 0);
    @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
